// File: rtl/multicycle_main_controller_pkg.sv
// Shared constants for the multicycle MIPS main controller and ALU controller:
// opcodes, alu_op classes, FSM state codes, datapath mux select encodings.
// Optional build macro: CTRL_JAL_EN (adds the JAL state and opcode).
package multicycle_main_controller_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // alu_op classes, decoded together with func by the ALU controller
    localparam logic [1:0] ALU_MTYPE = 2'b00;
    localparam logic [1:0] ALU_BTYPE = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_JTYPE = 2'b11;

    // FSM state codes
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_RD    = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WR    = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EXEC = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;
    localparam logic [3:0] S_JAL       = 4'd12;

    // Mux select encodings
    localparam logic       IORD_PC     = 1'b0;
    localparam logic       IORD_ALUOUT = 1'b1;
    localparam logic [1:0] DST_RT      = 2'b00;
    localparam logic [1:0] DST_RD      = 2'b01;
    localparam logic [1:0] DST_R31     = 2'b10;
    localparam logic [1:0] WD_ALUOUT   = 2'b00;
    localparam logic [1:0] WD_MDR      = 2'b01;
    localparam logic [1:0] WD_PC       = 2'b10;
    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_REG    = 1'b1;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;
    localparam logic [1:0] PCS_ALU     = 2'b00;
    localparam logic [1:0] PCS_ALUOUT  = 2'b01;
    localparam logic [1:0] PCS_JUMP    = 2'b10;

    // Decoded control word for one cycle
    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that stall on mem_ready
    function automatic logic is_wait_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_main_controller_if.sv
// Controller <-> datapath bundle: opcode/zero/mem_ready in, enables and selects out.
// master = controller side, slave = datapath/memory side.
interface multicycle_main_controller_if;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state_o;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, i_or_d, mem_read, mem_write, ir_write,
        output reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
        output alu_op, pc_source, illegal_op, mem_timeout, state_o
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, i_or_d, mem_read, mem_write, ir_write,
        input  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
        input  alu_op, pc_source, illegal_op, mem_timeout, state_o
    );

endinterface

// File: rtl/multicycle_main_controller_mem_wait_watchdog.sv
// Counts consecutive stalled memory-wait cycles and flags a timeout.
// Ports: clk, rst_n, i_waiting (wait state with mem_ready low), o_mem_timeout.
module mem_wait_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_waiting,
    output logic o_mem_timeout
);

    localparam logic        W_EN  = (TIMEOUT_CYCLES != 0);
    localparam int unsigned LIM   = (TIMEOUT_CYCLES != 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [15:0] W_LIM = LIM[15:0];

    logic [15:0] r_cnt;

    assign o_mem_timeout = W_EN && i_waiting && (r_cnt == W_LIM);

    // Any cycle that is not a stalled wait is a state change or a
    // completed access, so the count restarts; a timeout also forces FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_waiting || o_mem_timeout) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/multicycle_main_controller.sv
// Main control FSM of the multicycle MIPS datapath (Moore, 4-bit state).
// Ports: clk, rst_n (async, active low), bus (controller_if master modport).
// Optional build macro: CTRL_JAL_EN enables opcode 000011 -> JAL state.
module multicycle_main_controller
    import multicycle_main_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    multicycle_main_controller_if.master     bus
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    ctrl_t      w_ctrl;
    logic       w_illegal;
    logic       w_waiting;
    logic       w_timeout;

    assign w_waiting = is_wait_state(r_state) && !bus.mem_ready;

    mem_wait_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_waiting     (w_waiting),
        .o_mem_timeout (w_timeout)
    );

    always_comb begin
        w_ctrl    = '0;
        w_next    = S_FETCH;
        w_illegal = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.i_or_d    = IORD_PC;
                w_ctrl.alu_src_a = SRCA_PC;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_op    = ALU_MTYPE;
                w_ctrl.pc_source = PCS_ALU;
                w_ctrl.ir_write  = bus.mem_ready;
                w_ctrl.pc_write  = bus.mem_ready;
                w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_ctrl.alu_src_a = SRCA_PC;
                w_ctrl.alu_src_b = SRCB_IMMSH;
                w_ctrl.alu_op    = ALU_MTYPE;
                unique case (1'b1)
                    bus.opcode == OP_RTYPE: w_next = S_R_EXEC;
                    bus.opcode == OP_LW,
                    bus.opcode == OP_SW:    w_next = S_MEM_ADDR;
                    bus.opcode == OP_BEQ:   w_next = S_BRANCH;
                    bus.opcode == OP_J:     w_next = S_JUMP;
                    bus.opcode == OP_ADDI:  w_next = S_ADDI_EXEC;
`ifdef CTRL_JAL_EN
                    bus.opcode == OP_JAL:   w_next = S_JAL;
`endif
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_ctrl.alu_src_a = SRCA_REG;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALU_MTYPE;
                w_next = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.i_or_d   = IORD_ALUOUT;
                w_next = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = DST_RT;
                w_ctrl.mem_to_reg = WD_MDR;
            end
            S_MEM_WR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.i_or_d    = IORD_ALUOUT;
                w_next = bus.mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_R_EXEC: begin
                w_ctrl.alu_src_a = SRCA_REG;
                w_ctrl.alu_src_b = SRCB_REG;
                w_ctrl.alu_op    = ALU_RTYPE;
                w_next = S_R_WB;
            end
            S_R_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = DST_RD;
                w_ctrl.mem_to_reg = WD_ALUOUT;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a = SRCA_REG;
                w_ctrl.alu_src_b = SRCB_REG;
                w_ctrl.alu_op    = ALU_BTYPE;
                w_ctrl.pc_source = PCS_ALUOUT;
                w_ctrl.pc_write  = bus.zero;
            end
            S_JUMP: begin
                w_ctrl.pc_source = PCS_JUMP;
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.alu_op    = ALU_JTYPE;
            end
            S_ADDI_EXEC: begin
                w_ctrl.alu_src_a = SRCA_REG;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALU_MTYPE;
                w_next = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = DST_RT;
                w_ctrl.mem_to_reg = WD_ALUOUT;
            end
`ifdef CTRL_JAL_EN
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = DST_R31;
                w_ctrl.mem_to_reg = WD_PC;
                w_ctrl.pc_source  = PCS_JUMP;
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.alu_op     = ALU_JTYPE;
            end
`endif
            default: begin
                w_next    = S_FETCH;
                w_illegal = 1'b1;
            end
        endcase
        // Read/write requests stay as decoded; only the next state is overridden
        if (w_timeout) begin
            w_next = S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobes are gated by rst_n so they drop the instant reset asserts
    assign bus.pc_write    = w_ctrl.pc_write & rst_n;
    assign bus.ir_write    = w_ctrl.ir_write & rst_n;
    assign bus.mem_read    = w_ctrl.mem_read & rst_n;
    assign bus.mem_write   = w_ctrl.mem_write & rst_n;
    assign bus.reg_write   = w_ctrl.reg_write & rst_n;
    assign bus.i_or_d      = w_ctrl.i_or_d;
    assign bus.reg_dst     = w_ctrl.reg_dst;
    assign bus.mem_to_reg  = w_ctrl.mem_to_reg;
    assign bus.alu_src_a   = w_ctrl.alu_src_a;
    assign bus.alu_src_b   = w_ctrl.alu_src_b;
    assign bus.alu_op      = w_ctrl.alu_op;
    assign bus.pc_source   = w_ctrl.pc_source;
    assign bus.illegal_op  = w_illegal;
    assign bus.mem_timeout = w_timeout;
    assign bus.state_o     = r_state;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Randomized scoreboard bench for multicycle_main_controller (watchdog = 4).
// Works with or without CTRL_JAL_EN defined.
module tb_multicycle_main_controller;

    localparam int T = 4;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       mem_timeout;
        logic [3:0] state;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_main_controller_if bus ();

    multicycle_main_controller #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    obs_t exp_q[$];

    // reference model: current step of the instruction, stall count
    int ms = 0;
    int mcnt = 0;

    function automatic obs_t sample();
        obs_t o;
        o.pc_write    = bus.pc_write;
        o.i_or_d      = bus.i_or_d;
        o.mem_read    = bus.mem_read;
        o.mem_write   = bus.mem_write;
        o.ir_write    = bus.ir_write;
        o.reg_dst     = bus.reg_dst;
        o.mem_to_reg  = bus.mem_to_reg;
        o.reg_write   = bus.reg_write;
        o.alu_src_a   = bus.alu_src_a;
        o.alu_src_b   = bus.alu_src_b;
        o.alu_op      = bus.alu_op;
        o.pc_source   = bus.pc_source;
        o.illegal_op  = bus.illegal_op;
        o.mem_timeout = bus.mem_timeout;
        o.state       = bus.state_o;
        return o;
    endfunction

    // Expected outputs for one cycle and advance of the model
    task automatic model_step(input logic [5:0] opc, input logic z,
                              input logic mr, input logic rv,
                              output obs_t e);
        int nxt;
        bit waiting;
        e = '0;
        if (!rv) begin
            // in reset: FETCH decode with all strobes held low
            e.alu_src_b = 2'b01;
            ms = 0;
            mcnt = 0;
            return;
        end
        e.state = 4'(ms);
        nxt = 0;
        waiting = 1'b0;
        case (ms)
            0: begin
                e.mem_read = 1; e.alu_src_b = 2'b01;
                e.ir_write = mr; e.pc_write = mr;
                nxt = mr ? 1 : 0; waiting = !mr;
            end
            1: begin
                e.alu_src_b = 2'b11;
                if (opc == 6'h00) nxt = 6;
                else if (opc == 6'h23 || opc == 6'h2B) nxt = 2;
                else if (opc == 6'h04) nxt = 8;
                else if (opc == 6'h02) nxt = 9;
                else if (opc == 6'h08) nxt = 10;
`ifdef CTRL_JAL_EN
                else if (opc == 6'h03) nxt = 12;
`endif
                else begin nxt = 0; e.illegal_op = 1; end
            end
            2: begin
                e.alu_src_a = 1; e.alu_src_b = 2'b10;
                nxt = (opc == 6'h23) ? 3 : 5;
            end
            3: begin
                e.mem_read = 1; e.i_or_d = 1;
                nxt = mr ? 4 : 3; waiting = !mr;
            end
            4: begin e.reg_write = 1; e.mem_to_reg = 2'b01; end
            5: begin
                e.mem_write = 1; e.i_or_d = 1;
                nxt = mr ? 0 : 5; waiting = !mr;
            end
            6: begin e.alu_src_a = 1; e.alu_op = 2'b10; nxt = 7; end
            7: begin e.reg_write = 1; e.reg_dst = 2'b01; end
            8: begin
                e.alu_src_a = 1; e.alu_op = 2'b01;
                e.pc_source = 2'b01; e.pc_write = z;
            end
            9: begin e.pc_source = 2'b10; e.pc_write = 1; e.alu_op = 2'b11; end
            10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; nxt = 11; end
            11: begin e.reg_write = 1; end
            12: begin
                e.reg_write = 1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
                e.pc_source = 2'b10; e.pc_write = 1; e.alu_op = 2'b11;
            end
            default: begin e.illegal_op = 1; nxt = 0; end
        endcase
        if (waiting && mcnt == T - 1) begin
            e.mem_timeout = 1;
            nxt = 0;
            mcnt = 0;
        end else begin
            mcnt = waiting ? mcnt + 1 : 0;
        end
        ms = nxt;
    endtask

    function automatic logic [5:0] pick_opcode();
        logic [5:0] tbl [8];
        tbl = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h03, 6'h3F};
        if ($urandom_range(0, 9) == 0) return 6'($urandom);
        return tbl[$urandom_range(0, 7)];
    endfunction

    // Monitor: compare one expected control word per cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            obs_t a;
            e = exp_q.pop_front();
            a = sample();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctrl_word t=%0t got=%h expected=%h (state got %0d exp %0d)",
                         $time, a, e, a.state, e.state);
            end
        end
    end

    initial begin
        obs_t e;
        logic [5:0] opc;
        logic z, mr;
        int rst_hold;
        int lowbias;
        rst_n = 1'b0;
        bus.opcode = 6'h00;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        rst_hold = 2;
        opc = 6'h00;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #2;
            lowbias = (cyc % 1000 < 300) ? 7 : 3;
            if (ms == 0) opc = pick_opcode();
            z  = 1'($urandom_range(0, 1));
            mr = ($urandom_range(0, 9) >= lowbias);
            if (rst_hold == 0 && ms == 5 && rst_n && $urandom_range(0, 5) == 0) begin
                rst_n = 1'b0;
                rst_hold = $urandom_range(1, 2);
                #1;
                checks++;
                if (bus.mem_write !== 1'b0 || bus.state_o !== 4'd0) begin
                    errors++;
                    $display("FAIL async_reset got mem_write=%b state=%0d expected 0/0",
                             bus.mem_write, bus.state_o);
                end
            end else if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end
            bus.opcode = opc;
            bus.zero = z;
            bus.mem_ready = mr;
            model_step(opc, z, mr, rst_n, e);
            exp_q.push_back(e);
        end
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_main_controller.md
Name: multicycle_main_controller

Overview:
- Main control FSM of the multicycle MIPS datapath; drives the `alu_op` bus that the ALU controller decodes with `func`.
- Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction and emits all datapath enables and mux selects.
- Waits on memory through a `mem_ready` handshake, with an optional watchdog.

Parameters:
- TIMEOUT_CYCLES, 0, consecutive `mem_ready`-low cycles in a wait state before abort; 0 disables the watchdog; max 65535.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current read/write this cycle
- pc_write  output  1  PC load strobe
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load strobe
- reg_dst  output  2  write-register select: 00 = rt, 01 = rd, 10 = r31
- mem_to_reg  output  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC
- reg_write  output  1  register file write
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = A register
- alu_src_b  output  2  ALU B select: 00 = B, 01 = 4, 10 = signext, 11 = signext<<2
- alu_op  output  2  00 = MTYPE (add), 01 = BTYPE (sub), 10 = RTYPE (use func), 11 = JTYPE
- pc_source  output  2  PC input select: 00 = ALU, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  one-cycle flag: unmapped opcode seen in DECODE
- mem_timeout  output  1  one-cycle flag: watchdog expired
- state_o  output  4  current state, for debug

Behaviour:

Structure:
- Moore FSM with a 4-bit state register; outputs decode from state, qualified by `mem_ready` and `zero` where noted.
- Any output not listed for a state is 0.
- `rst_n` low, asynchronous: state = FETCH, wait counter = 0, and every strobe (`pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write`) is forced to 0 while `rst_n` is low.
- Reset mid-instruction abandons that instruction; fetch restarts on the first clock after release.

States and outputs:
- FETCH(0): `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stay in FETCH while `mem_ready`=0; go to DECODE on `mem_ready`.
- DECODE(1): `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (precomputes branch target). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 / 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC
  - 000011 -> JAL (feature only)
  - anything else -> `illegal_op`=1 this cycle, next state FETCH
- MEM_ADDR(2): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next: MEM_RD if opcode is lw, else MEM_WR.
- MEM_RD(3): `mem_read`=1, `i_or_d`=1. Go to MEM_WB on `mem_ready`, else hold.
- MEM_WB(4): `reg_write`=1, `reg_dst`=00, `mem_to_reg`=01. Next FETCH.
- MEM_WR(5): `mem_write`=1, `i_or_d`=1. Go to FETCH on `mem_ready`, else hold.
- R_EXEC(6): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next R_WB.
- R_WB(7): `reg_write`=1, `reg_dst`=01, `mem_to_reg`=00. Next FETCH.
- BRANCH(8): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=01, `pc_write`=`zero`. Next FETCH.
- JUMP(9): `pc_source`=10, `pc_write`=1, `alu_op`=11. Next FETCH.
- ADDI_EXEC(10): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next ADDI_WB.
- ADDI_WB(11): `reg_write`=1, `reg_dst`=00, `mem_to_reg`=00. Next FETCH.
- Codes 12–15: unused; if reached, go to FETCH and assert `illegal_op`.

Latency in cycles, assuming zero-wait memory:
- R-type 4; lw 5; sw 4; beq 3; j 3; addi 4; jal 3.

Watchdog (applies when TIMEOUT_CYCLES > 0):
- A 16-bit counter increments on each cycle in FETCH, MEM_RD or MEM_WR with `mem_ready`=0.
- It clears on any state change or when `mem_ready`=1.
- When counter == TIMEOUT_CYCLES-1 and `mem_ready`=0:
  - `mem_timeout`=1 for that cycle;
  - `mem_read` and `mem_write` stay as decoded for that cycle;
  - next state FETCH (FETCH re-enters itself) and the counter clears.
- `mem_ready` and timeout in the same cycle: `mem_ready` wins and there is no timeout.

Optional Feature:
- Macro: `CTRL_JAL_EN`.
- Defined: opcode 000011 -> JAL(12). JAL outputs: `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10, `pc_source`=10, `pc_write`=1, `alu_op`=11. Next FETCH. The PC was already incremented in FETCH, so the link value is PC+4.
- Undefined: 000011 is illegal, and state 12 is unused.
- Port widths are identical in both builds.

Decomposition:
- Shared header `constant_values.vh`:
  - opcode constants;
  - `alu_op` encodings MTYPE/BTYPE/RTYPE/JTYPE (move out of the ALU controller's local parameters so both ends share them);
  - state codes;
  - mux select encodings.
- One natural sub-module: `mem_wait_watchdog` (counter plus compare, emitting `mem_timeout`).
- The FSM next-state and output decode stay in the top module.

Test Plan:
- R-type add, `mem_ready` tied 1: `state_o` sequence 0,1,6,7,0. `alu_op`=10 in R_EXEC. `reg_write`=1 with `reg_dst`=01 in R_WB only.
- lw with `mem_ready` low for 3 cycles in MEM_RD (TIMEOUT_CYCLES=0): `state_o` holds 3 for 4 cycles; MEM_WB follows with `mem_to_reg`=01; total 8 cycles.
- beq, first with `zero`=1 then with `zero`=0: in BRANCH, `pc_write`=1 then 0; `alu_op`=01 and `pc_source`=01 both times.
- Opcode 111111: `illegal_op` high exactly 1 cycle in DECODE; next `state_o`=0; no write strobes asserted.
- TIMEOUT_CYCLES=4, `mem_ready` stuck 0 in MEM_WR: `mem_timeout` pulses in the 4th wait cycle; `state_o` -> 0 next cycle.
- `rst_n` asserted mid-MEM_WR: strobes drop immediately (asynchronous); after release `state_o`=0. With `CTRL_JAL_EN` defined, opcode 000011 gives `state_o` 0,1,12,0 with `reg_dst`=10 and `pc_write`=1.
